// File: rtl/m_mem_arbiter.sv
// m_mem_arbiter
// Two-master round-robin arbiter for the program-memory data port.
// Master 0 is the CPU data bus and master 1 is the bootstrap/debug loader.
// Each tenure carries exactly one strobe/ack transfer. The port is released
// on ack, on master abort (strobe dropped), or on a watchdog timeout. A
// timeout reports err to the stalled master.
//
// Ports
//   dat_clk_i, dat_rst_i        : clock, async active-low reset
//   mX_adr_i/dat_i/we_i/stb_i   : master X request
//   mX_dat_o/ack_o/err_o        : master X response (read data is broadcast)
//   s_adr_o/dat_o/we_o/stb_o    : memory request (combinational pass-through)
//   s_dat_i/ack_i               : memory response
//   owner_o                     : 00 idle, 01 master 0, 10 master 1
//
// state | meaning
// IDLE  | no owner; arbitrate pending strobes
// OWN0  | master 0 owns the memory port for one transfer
// OWN1  | master 1 owns the memory port for one transfer

module m_mem_arbiter #(
    parameter int AW      = 13,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          dat_clk_i,
    input  logic          dat_rst_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    input  logic          m0_we_i,
    input  logic          m0_stb_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    input  logic          m1_we_i,
    input  logic          m1_stb_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    output logic          s_we_o,
    output logic          s_stb_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,
    output logic [1:0]    owner_o
);

    // The encoding doubles as the owner_o code, so owner_o comes straight
    // from the state flops and cannot glitch.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_e;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] wd_q, wd_d;

    logic own0, own1;
    logic own_stb, own_we;
    logic wd_hit, timeout;

    assign own0    = (state_q == OWN0);
    assign own1    = (state_q == OWN1);
    assign own_stb = (own0 & m0_stb_i) | (own1 & m1_stb_i);
    assign own_we  = (own0 & m0_we_i)  | (own1 & m1_we_i);
    assign wd_hit  = (wd_q == WD_LAST);
    // A same-cycle ack completes the transfer, so it suppresses the timeout.
    assign timeout = own_stb & ~s_ack_i & wd_hit;

    assign s_adr_o = own1 ? m1_adr_i : m0_adr_i;
    assign s_dat_o = own1 ? m1_dat_i : m0_dat_i;
    assign s_stb_o = own_stb & ~timeout;
    assign s_we_o  = own_we & own_stb & ~timeout;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = own0 & s_ack_i;
    assign m1_ack_o = own1 & s_ack_i;
    assign m0_err_o = own0 & timeout;
    assign m1_err_o = own1 & timeout;

    assign owner_o = state_q;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        wd_d    = wd_q;
        unique case (state_q)
            IDLE: begin
                // Both requesting: grant the master that did not win last time.
                if (m0_stb_i && m1_stb_i) begin
                    state_d = last_q ? OWN0 : OWN1;
                    last_d  = ~last_q;
                    wd_d    = 8'd0;
                end else if (m0_stb_i) begin
                    state_d = OWN0;
                    last_d  = 1'b0;
                    wd_d    = 8'd0;
                end else if (m1_stb_i) begin
                    state_d = OWN1;
                    last_d  = 1'b1;
                    wd_d    = 8'd0;
                end
            end
            OWN0, OWN1: begin
                // Ack, abort and timeout all release the port; only the
                // reported outcome differs.
                if (s_ack_i || !own_stb || wd_hit) begin
                    state_d = IDLE;
                end else if (wd_q != 8'hFF) begin
                    wd_d = wd_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge dat_clk_i or negedge dat_rst_i) begin
        if (!dat_rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            wd_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

endmodule

// File: tb/tb_m_mem_arbiter.sv
module tb_m_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [12:0] m0_adr = '0, m1_adr = '0, s_adr;
    logic [15:0] m0_dat = '0, m1_dat = '0, s_dat, m0_rd, m1_rd, s_rd = '0;
    logic        m0_we = 0, m1_we = 0, m0_stb = 0, m1_stb = 0;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic        s_we, s_stb, s_ack = 0;
    logic [1:0]  owner;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          m;
        logic [15:0] d;
    } exp_t;
    exp_t sb[$];

    m_mem_arbiter #(.AW(13), .DW(16), .TIMEOUT(15)) dut (
        .dat_clk_i (clk),
        .dat_rst_i (rst_n),
        .m0_adr_i  (m0_adr),
        .m0_dat_i  (m0_dat),
        .m0_we_i   (m0_we),
        .m0_stb_i  (m0_stb),
        .m0_dat_o  (m0_rd),
        .m0_ack_o  (m0_ack),
        .m0_err_o  (m0_err),
        .m1_adr_i  (m1_adr),
        .m1_dat_i  (m1_dat),
        .m1_we_i   (m1_we),
        .m1_stb_i  (m1_stb),
        .m1_dat_o  (m1_rd),
        .m1_ack_o  (m1_ack),
        .m1_err_o  (m1_err),
        .s_adr_o   (s_adr),
        .s_dat_o   (s_dat),
        .s_we_o    (s_we),
        .s_stb_o   (s_stb),
        .s_dat_i   (s_rd),
        .s_ack_i   (s_ack),
        .owner_o   (owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every forwarded ack must match the oldest expected transfer.
    always @(negedge clk) begin
        if (rst_n && (m0_ack || m1_ack)) begin
            exp_t e;
            if (sb.size() == 0) begin
                chk("sb_unexpected_ack", {m1_ack, m0_ack}, 2'b00);
            end else begin
                e = sb.pop_front();
                chk("sb_ack_master", {m1_ack, m0_ack}, (e.m == 0) ? 2'b01 : 2'b10);
                chk("sb_rdata", (e.m == 0) ? m0_rd : m1_rd, e.d);
            end
        end
    end

    // Ack the current owner m with read data d, then check the dead cycle.
    task automatic ack_xfer(input int m, input logic [15:0] d);
        tick();
        s_ack = 1'b1;
        s_rd  = d;
        sb.push_back('{m: m, d: d});
        #1;
        chk("ack_m0", m0_ack, (m == 0));
        chk("ack_m1", m1_ack, (m == 1));
        chk("ack_no_err", {m1_err, m0_err}, 2'b00);
        tick();
        s_ack = 1'b0;
        #1;
        chk("dead_idle", owner, 2'b00);
    endtask

    initial begin
        // ---- reset state
        #12;
        chk("rst_owner", owner, 2'b00);
        chk("rst_stb", s_stb, 1'b0);
        chk("rst_acks", {m1_err, m0_err, m1_ack, m0_ack}, 4'b0000);
        #5 rst_n = 1'b1;

        // ---- m0 read only
        tick();
        m0_stb = 1'b1;
        m0_adr = 13'h0123;
        #1;
        chk("t1_idle_owner", owner, 2'b00);
        chk("t1_idle_stb", s_stb, 1'b0);
        tick();
        #1;
        chk("t1_grant_owner", owner, 2'b01);
        chk("t1_grant_stb", s_stb, 1'b1);
        chk("t1_adr", s_adr, 13'h0123);
        chk("t1_we", s_we, 1'b0);
        tick();
        s_ack = 1'b1;
        s_rd  = 16'hBEEF;
        sb.push_back('{m: 0, d: 16'hBEEF});
        #1;
        chk("t1_ack", m0_ack, 1'b1);
        chk("t1_rdata", m0_rd, 16'hBEEF);
        tick();
        s_ack  = 1'b0;
        m0_stb = 1'b0;
        #1;
        chk("t1_release", owner, 2'b00);

        // ---- simultaneous requests from reset: m0, m1, m0, m1
        tick();
        rst_n = 1'b0;
        #4 rst_n = 1'b1;
        tick();
        m0_stb = 1'b1; m0_adr = 13'h0010; m0_we = 1'b0;
        m1_stb = 1'b1; m1_adr = 13'h1FFF; m1_dat = 16'h5A5A; m1_we = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            chk("rr_owner", owner, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_stb", s_stb, 1'b1);
            if (k % 2 == 1) begin
                chk("rr_m1_adr", s_adr, 13'h1FFF);
                chk("rr_m1_dat", s_dat, 16'h5A5A);
                chk("rr_m1_we", s_we, 1'b1);
            end else begin
                chk("rr_m0_adr", s_adr, 13'h0010);
                chk("rr_m0_we", s_we, 1'b0);
            end
            ack_xfer(k % 2, 16'h1000 + 16'(k));
        end
        m0_stb = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;

        // ---- timeout on m1, m0 pending
        tick();
        rst_n = 1'b0;
        #4 rst_n = 1'b1;
        tick();
        m1_stb = 1'b1;
        tick();
        #1;
        chk("to_grant", owner, 2'b10);
        m0_stb = 1'b1;
        for (int c = 1; c < 15; c++) begin
            #1;
            chk("to_wait_err", {m1_err, m0_err}, 2'b00);
            chk("to_wait_stb", s_stb, 1'b1);
            tick();
        end
        #1;
        chk("to_err", {m1_err, m0_err}, 2'b10);
        chk("to_stb_forced", s_stb, 1'b0);
        tick();
        #1;
        chk("to_idle", owner, 2'b00);
        chk("to_err_pulse", m1_err, 1'b0);
        m1_stb = 1'b0;
        tick();
        #1;
        chk("to_m0_next", owner, 2'b01);

        // ---- ack coincident with timeout on m0's 15th owned cycle
        for (int c = 1; c < 14; c++) tick();
        tick();
        s_ack = 1'b1;
        s_rd  = 16'hC0DE;
        sb.push_back('{m: 0, d: 16'hC0DE});
        #1;
        chk("co_ack", m0_ack, 1'b1);
        chk("co_err", m0_err, 1'b0);
        chk("co_stb", s_stb, 1'b1);
        tick();
        s_ack  = 1'b0;
        m0_stb = 1'b0;
        #1;
        chk("co_idle", owner, 2'b00);

        // ---- m0 abort, then stray ack while idle
        tick();
        m0_stb = 1'b1;
        tick();
        #1;
        chk("ab_grant", owner, 2'b01);
        tick();
        m0_stb = 1'b0;
        #1;
        chk("ab_stb", s_stb, 1'b0);
        chk("ab_resp", {m1_err, m0_err, m1_ack, m0_ack}, 4'b0000);
        tick();
        #1;
        chk("ab_idle", owner, 2'b00);
        tick();
        s_ack = 1'b1;
        #1;
        chk("ab_stray", {m1_ack, m0_ack}, 2'b00);
        tick();
        s_ack = 1'b0;

        // ---- async reset mid-OWN0, then tie-break favours m0
        m0_stb = 1'b1;
        tick();
        #1;
        chk("ar_grant", owner, 2'b01);
        #1;
        s_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("ar_stb", s_stb, 1'b0);
        chk("ar_ack", m0_ack, 1'b0);
        chk("ar_owner", owner, 2'b00);
        s_ack  = 1'b0;
        m1_stb = 1'b1;
        #8 rst_n = 1'b1;
        tick();
        #1;
        chk("ar_tiebreak", owner, 2'b01);
        ack_xfer(0, 16'h7E57);
        m0_stb = 1'b0; m1_stb = 1'b0;
        tick();
        tick();
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
